// File: rtl/row_collapse_pkg.sv
// row_collapse_pkg: board geometry, state encoding and helpers for the line-clear engine
package row_collapse_pkg;

    localparam int ROWS = 20;
    localparam int COLS = 10;
    localparam int IW = 5;

    localparam logic [IW-1:0] NO_ROW = IW'(ROWS);
    localparam logic [IW-1:0] TOP_ROW = IW'(ROWS - 1);

    typedef enum logic [2:0] {IDLE, CHECK, READ, COPY, TOP, SETTLE, DONE} state_t;

    function automatic logic [2:0] sat_inc(input logic [2:0] v);
        return (v == 3'd7) ? v : v + 3'd1;
    endfunction

endpackage

// File: rtl/row_collapse_if.sv
// row_collapse_if: start/encoder/board-RAM/result bundle between the engine and its neighbours
interface row_collapse_if;
    import row_collapse_pkg::*;

    logic            start;
    logic [IW-1:0]   clear_index;
    logic [IW-1:0]   rd_addr;
    logic [COLS-1:0] rd_data;
    logic            wr_en;
    logic [IW-1:0]   wr_addr;
    logic [COLS-1:0] wr_data;
    logic            busy;
    logic            done;
    logic [2:0]      lines_cleared;

    modport master (
        input  start, clear_index, rd_data,
        output rd_addr, wr_en, wr_addr, wr_data, busy, done, lines_cleared
    );

    modport slave (
        output start, clear_index, rd_data,
        input  rd_addr, wr_en, wr_addr, wr_data, busy, done, lines_cleared
    );

endinterface

// File: rtl/row_collapse.sv
// row_collapse: removes full rows by shifting the board down one row at a time until none remain
module row_collapse
    import row_collapse_pkg::*;
(
    input  logic clk,
    input  logic reset,
    row_collapse_if.master bus
);

    state_t        state, state_next;
    logic [IW-1:0] r;
    logic [IW-1:0] r_up;
    logic [2:0]    cnt;
    logic [2:0]    lines;
    logic          none;

    assign r_up = r + IW'(1);
    // any index at or above ROWS means the encoder found nothing
    assign none = bus.clear_index >= NO_ROW;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = bus.start ? CHECK : IDLE;
            CHECK:   state_next = none ? DONE : (bus.clear_index == TOP_ROW) ? TOP : READ;
            READ:    state_next = COPY;
            COPY:    state_next = (r_up == TOP_ROW) ? TOP : READ;
            TOP:     state_next = SETTLE;
            SETTLE:  state_next = CHECK;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r <= '0;
            cnt <= '0;
            lines <= '0;
        end else begin
            if (state == IDLE && bus.start) cnt <= '0;
            if (state == CHECK && !none) r <= bus.clear_index;
            if (state == CHECK && none) lines <= cnt;
            if (state == COPY) r <= r_up;
            if (state == TOP) cnt <= sat_inc(cnt);
        end
    end

    // rd_data arrives in COPY for the address presented in READ
    always_comb begin
        bus.rd_addr = (state == READ) ? r_up : '0;
        bus.wr_en = (state == COPY) || (state == TOP);
        bus.wr_addr = (state == COPY) ? r : (state == TOP) ? TOP_ROW : '0;
        bus.wr_data = (state == COPY) ? bus.rd_data : '0;
        bus.busy = state != IDLE;
        bus.done = state == DONE;
        bus.lines_cleared = lines;
    end

endmodule

// File: tb/tb_row_collapse.sv
// tb_row_collapse: random and directed boards checked against a queue-based row-removal model
module tb_row_collapse;
    import row_collapse_pkg::*;

    logic clk = 0;
    logic reset = 1;
    logic load = 0;
    logic [COLS-1:0] ram [ROWS];
    logic [COLS-1:0] img [ROWS];
    logic [COLS-1:0] exp_b [ROWS];
    int exp_cyc, exp_wr, exp_lines;
    int n_chk = 0, n_pass = 0;

    row_collapse_if bus();

    row_collapse dut (.clk(clk), .reset(reset), .bus(bus.master));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < ROWS; i++) ram[i] <= img[i];
        end else if (bus.wr_en && bus.wr_addr < IW'(ROWS)) begin
            ram[bus.wr_addr] <= bus.wr_data;
        end
        bus.rd_data <= (bus.rd_addr < IW'(ROWS)) ? ram[bus.rd_addr] : '0;
    end

    // encoder: highest row whose bits are all set
    always_comb begin
        bus.clear_index = NO_ROW;
        for (int i = 0; i < ROWS; i++) if (&ram[i]) bus.clear_index = IW'(i);
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // delete the highest full row, push an empty row on top, repeat
    task automatic model();
        logic [COLS-1:0] q[$];
        int h;
        q = {};
        for (int i = 0; i < ROWS; i++) q.push_back(img[i]);
        exp_cyc = 2;
        exp_wr = 0;
        exp_lines = 0;
        do begin
            h = -1;
            for (int i = 0; i < ROWS; i++) if (&q[i]) h = i;
            if (h >= 0) begin
                exp_cyc += 2 * (ROWS - 1 - h) + 3;
                exp_wr += ROWS - h;
                exp_lines = (exp_lines == 7) ? 7 : exp_lines + 1;
                q.delete(h);
                q.push_back('0);
            end
        end while (h >= 0);
        for (int i = 0; i < ROWS; i++) exp_b[i] = q[i];
    endtask

    task automatic load_board();
        load = 1;
        @(posedge clk); #1;
        load = 0;
        @(posedge clk); #1;
    endtask

    task automatic run_pass(input string tag);
        int k, wr;
        model();
        bus.start = 1;
        @(posedge clk); #1;
        bus.start = 0;
        k = 1;
        wr = 0;
        chk({tag, "_busy"}, int'(bus.busy), 1);
        while (!bus.done && k < 1500) begin
            wr += int'(bus.wr_en);
            @(posedge clk); #1;
            k++;
        end
        chk({tag, "_cycles"}, k, exp_cyc);
        chk({tag, "_lines"}, int'(bus.lines_cleared), exp_lines);
        chk({tag, "_writes"}, wr, exp_wr);
        @(posedge clk); #1;
        chk({tag, "_done_low"}, int'(bus.done), 0);
        chk({tag, "_idle"}, int'(bus.busy), 0);
        for (int i = 0; i < ROWS; i++) chk($sformatf("%s_row%0d", tag, i), int'(ram[i]), int'(exp_b[i]));
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_done"}, int'(bus.done), 0);
        chk({tag, "_wr_en"}, int'(bus.wr_en), 0);
        chk({tag, "_rd_addr"}, int'(bus.rd_addr), 0);
        chk({tag, "_wr_addr"}, int'(bus.wr_addr), 0);
        chk({tag, "_wr_data"}, int'(bus.wr_data), 0);
        chk({tag, "_lines"}, int'(bus.lines_cleared), 0);
    endtask

    initial begin
        int dones, busy_cnt;
        bus.start = 0;
        for (int i = 0; i < ROWS; i++) img[i] = '0;
        load = 1;
        repeat (3) @(posedge clk);
        #1;
        load = 0;
        check_idle_outputs("reset");
        reset = 0;
        @(posedge clk); #1;

        run_pass("empty");

        for (int i = 0; i < ROWS; i++) img[i] = (i == 0) ? '1 : COLS'(i);
        load_board();
        run_pass("row0");

        for (int i = 0; i < ROWS; i++) img[i] = (i < 4) ? '1 : COLS'(i * 3 + 1);
        load_board();
        run_pass("tetris");

        for (int i = 0; i < ROWS; i++) img[i] = (i == ROWS - 1) ? '1 : COLS'(i + 40);
        load_board();
        run_pass("top_only");

        for (int i = 0; i < ROWS; i++) img[i] = (i == 5 || i == 7) ? '1 : COLS'(i * 7 + 2);
        load_board();
        run_pass("rows5_7");

        for (int i = 0; i < ROWS; i++) img[i] = (i < 9) ? '1 : COLS'(i + 100);
        load_board();
        run_pass("saturate");

        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < ROWS; i++)
                img[i] = ($urandom_range(0, 3) == 0) ? '1 : COLS'($urandom_range(0, (1 << COLS) - 2));
            load_board();
            run_pass($sformatf("rand%0d", t));
        end

        for (int i = 0; i < ROWS; i++) img[i] = '0;
        load_board();
        bus.start = 1;
        @(posedge clk); #1;
        bus.start = 0;
        @(posedge clk); #1;
        chk("b2b_done", int'(bus.done), 1);
        bus.start = 1;
        @(posedge clk); #1;
        bus.start = 0;
        chk("b2b_ignored", int'(bus.busy), 0);
        run_pass("b2b_accept");

        for (int i = 0; i < ROWS; i++) img[i] = (i == 0) ? '1 : COLS'(i);
        load_board();
        bus.start = 1;
        @(posedge clk); #1;
        bus.start = 0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("rst_in_copy", int'(bus.wr_en), 1);
        reset = 1;
        @(posedge clk); #1;
        check_idle_outputs("rst_mid");
        reset = 0;

        for (int i = 0; i < ROWS; i++) img[i] = (i == ROWS - 1) ? '1 : COLS'(i + 40);
        load_board();
        bus.start = 1;
        @(posedge clk); #1;
        bus.start = 0;
        dones = 0;
        busy_cnt = 0;
        for (int k = 1; k <= 14; k++) begin
            bus.start = (k == 2);
            dones += int'(bus.done);
            if (k > 5) busy_cnt += int'(bus.busy);
            @(posedge clk); #1;
        end
        bus.start = 0;
        chk("busy_start_dones", dones, 1);
        chk("busy_start_no_pass", busy_cnt, 0);
        chk("busy_start_lines", int'(bus.lines_cleared), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
